// File: rtl/multi_debouncer.sv
// Multi-channel button/switch debouncer: per-channel synchroniser, consecutive-mismatch
// qualification, registered edge pulses and optional long-press / auto-repeat pulses.
module multi_debouncer #(
   parameter int              N_CH        = 4,
   parameter int              DELAY       = 1_000_000,
   parameter int              SYNC_STAGES = 2,
   parameter int              LONG_PRESS  = 50_000_000,
   parameter int              REPEAT      = 0,
   parameter logic [N_CH-1:0] INVERT      = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] btn_in,
   output logic [N_CH-1:0] btn_db,
   output logic [N_CH-1:0] rise,
   output logic [N_CH-1:0] fall,
   output logic [N_CH-1:0] long_press,
   output logic            any_active
);

   localparam int              CW       = $clog2(DELAY + 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DELAY - 1);

   logic [N_CH-1:0] sync_q [SYNC_STAGES];
   logic [N_CH-1:0] sync;

   // NOTE: the synchroniser chain is reset too, so an inverted channel whose pin idles
   // high reads inactive until its level has been fully re-qualified after reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= btn_in ^ INVERT;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   assign sync = sync_q[SYNC_STAGES-1];

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [CW-1:0] cnt_q, cnt_d;
      logic          db_q, db_d;
      logic          rise_q, fall_q;

      // NOTE: every always_comb output gets a default first so no latch can be inferred.
      always_comb begin
         cnt_d = '0;
         db_d  = db_q;
         if (sync[i] != db_q) begin
            if (cnt_q == CNT_LAST) db_d  = sync[i];
            else                   cnt_d = cnt_q + CW'(1);
         end
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            cnt_q  <= '0;
            db_q   <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
         end else begin
            cnt_q  <= cnt_d;
            db_q   <= db_d;
            rise_q <= db_d & ~db_q;
            fall_q <= ~db_d & db_q;
         end
      end

      assign btn_db[i] = db_q;
      assign rise[i]   = rise_q;
      assign fall[i]   = fall_q;

      if (LONG_PRESS > 0) begin : g_hold
         localparam int            HW        = $clog2(LONG_PRESS + REPEAT + 1);
         localparam logic [HW-1:0] HOLD_LP   = HW'(LONG_PRESS);
         localparam logic [HW-1:0] HOLD_WRAP = HW'(LONG_PRESS + REPEAT);

         logic [HW-1:0] hold_q, hold_d;
         logic          lp_q, lp_d;

         // Counts only while the level stays high; rise and fall edges both restart it.
         always_comb begin
            hold_d = '0;
            lp_d   = 1'b0;
            if (db_q && db_d) begin
               if (REPEAT == 0 && hold_q == HOLD_LP) begin
                  hold_d = hold_q;
               end else begin
                  hold_d = hold_q + HW'(1);
                  if (hold_d == HOLD_LP) lp_d = 1'b1;
                  if (REPEAT > 0 && hold_d == HOLD_WRAP) begin
                     hold_d = HOLD_LP;
                     lp_d   = 1'b1;
                  end
               end
            end
         end

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               hold_q <= '0;
               lp_q   <= 1'b0;
            end else begin
               hold_q <= hold_d;
               lp_q   <= lp_d;
            end
         end

         assign long_press[i] = lp_q;
      end else begin : g_no_hold
         assign long_press[i] = 1'b0;
      end
   end

   assign any_active = |btn_db;

endmodule

// File: doc/multi_debouncer.md
MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001: Parameter N_CH, default 4: number of independent button/switch channels, range 1..32.
REQ-002: Parameter DELAY, default 1_000_000: consecutive synchronised-mismatch cycles required to accept a new level, range 2..2^24.
REQ-003: Parameter SYNC_STAGES, default 2: input synchroniser flip-flop stages, range 2..4.
REQ-004: Parameter LONG_PRESS, default 50_000_000: held cycles after an accepted press before the first long_press pulse; 0 disables long-press detection.
REQ-005: Parameter REPEAT, default 0: cycles between repeated long_press pulses while still held; 0 means one pulse per press.
REQ-006: Parameter INVERT, default all zeros, N_CH bits: a 1 in bit i marks channel i as active-low at the pin.
REQ-007: clk  input  1  single system clock; all logic on the rising edge.
REQ-008: rst_n  input  1  reset, synchronous, active-low.
REQ-009: btn_in  input  N_CH  raw asynchronous button/switch levels.
REQ-010: btn_db  output  N_CH  debounced level per channel, active-high after INVERT is applied.
REQ-011: rise  output  N_CH  one-cycle pulse when btn_db[i] goes 0->1.
REQ-012: fall  output  N_CH  one-cycle pulse when btn_db[i] goes 1->0.
REQ-013: long_press  output  N_CH  one-cycle pulse per long-press / repeat event.
REQ-014: any_active  output  1  OR of all btn_db bits.

Function
REQ-015: Each channel passes btn_in[i] XOR INVERT[i] through a SYNC_STAGES-deep flip-flop chain; only the last stage (sync[i]) feeds the debounce logic.
REQ-016: Each channel has a mismatch counter of width $clog2(DELAY+1) that increments on every cycle where sync[i] != btn_db[i].
REQ-017: The mismatch counter clears to 0 on any cycle where sync[i] == btn_db[i]; mismatch cycles therefore must be consecutive.
REQ-018: When sync[i] != btn_db[i] and the counter equals DELAY-1, btn_db[i] takes the value of sync[i] on that edge, and the counter clears.
REQ-019: Latency: a clean input step is visible on btn_db exactly SYNC_STAGES+DELAY rising edges after it is first sampled.
REQ-020: rise[i] and fall[i] are registered and assert on the same edge that btn_db[i] changes, for exactly one cycle; they are never both high.
REQ-021: Each channel has a hold counter of width $clog2(LONG_PRESS+REPEAT+1) that clears on the edge btn_db[i] rises and increments on every cycle while btn_db[i] is 1.
REQ-022: long_press[i] pulses for one cycle when the hold counter reaches LONG_PRESS, i.e. LONG_PRESS edges after the rise pulse.
REQ-023: If REPEAT>0, long_press[i] pulses again every REPEAT cycles after the first pulse while btn_db[i] stays 1; the hold counter reloads to LONG_PRESS at each repeat and never overflows.
REQ-024: If REPEAT=0, the hold counter saturates at LONG_PRESS after the first pulse.
REQ-025: A fall clears the hold counter on the same edge; no long_press is issued on the cycle where fall is asserted.
REQ-026: If LONG_PRESS=0, long_press is tied to 0 and no hold counter logic exists.
REQ-027: Channels are fully independent; simultaneous events on any number of channels produce simultaneous per-bit pulses.
REQ-028: any_active is a combinational OR of the btn_db register bits.

Reset
REQ-029: While rst_n is 0 at a rising edge, all synchroniser stages, btn_db, counters, rise, fall and long_press clear to 0; any_active is therefore 0.
REQ-030: A reset asserted mid-count discards all partial counts. A button still held at reset release re-qualifies with full SYNC_STAGES+DELAY latency and produces a fresh rise pulse.
REQ-031: Because synchroniser stages reset to 0, an INVERT channel whose pin idles high reads inactive during and immediately after reset.

Verification (N_CH=2, DELAY=4, SYNC_STAGES=2, LONG_PRESS=10, REPEAT=5, INVERT=2'b10 unless stated)
REQ-032: btn_in[0] set to 1 and held -> btn_db[0]=1 and rise[0]=1 for one cycle after edge 6; any_active=1 from the same cycle.
REQ-033: btn_in[0] pulsed high for 3 cycles, then low -> btn_db[0], rise[0] and fall[0] stay 0 throughout.
REQ-034: btn_in[0] held for 30 cycles after btn_db[0] rises -> long_press[0] pulses at hold edges 10, 15, 20, 25 and 30; release gives fall[0] 6 edges later and no further long_press.
REQ-035: btn_in[1] held at 1 from reset -> btn_db[1] stays 0; btn_in[1] driven to 0 -> btn_db[1]=1 after 6 edges.
REQ-036: Both channels stepped on the same cycle -> rise=2'b11 on the same edge.
REQ-037: rst_n driven low for 1 cycle with btn_db[0]=1 held -> all outputs 0 on the next cycle; rise[0] returns 6 edges after rst_n goes high.
